// File: rtl/sensor_level_conditioner.sv
// sensor_level_conditioner
// Tank level front end. It synchronises the enable switch and the three level
// probes, debounces each probe, and rejects level codes that are not
// physically possible. It then drives the pump request with hysteresis and
// raises the sensor fault flag when the probe readings stay inconsistent.
module sensor_level_conditioner #(
    parameter int DEB_CYCLES   = 16,
    parameter int FAULT_CYCLES = 8,
    parameter int CLEAR_CYCLES = 32,
    parameter int CW           = 6
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic l_in,
    input  logic m_in,
    input  logic h_in,
    output logic l,
    output logic m,
    output logic h,
    output logic bs,
    output logic m7
);

    typedef enum logic [1:0] {
        NORMAL  = 2'd0,
        SUSPECT = 2'd1,
        FAULT   = 2'd2
    } state_t;

    logic [3:0]         sync_1;
    logic [3:0]         sync_2;
    logic               s_en;
    logic [2:0]         s_probe;
    logic [2:0]         deb;
    logic [2:0][CW-1:0] deb_cnt;
    logic               code_valid;

    state_t             state;
    state_t             state_n;
    logic [CW-1:0]      fcnt;
    logic [CW-1:0]      fcnt_n;
    logic [CW-1:0]      ccnt;
    logic [CW-1:0]      ccnt_n;
    logic               h_n;
    logic               m_n;
    logic               l_n;
    logic               bs_n;
    logic               m7_n;

    assign s_en    = sync_2[3];
    assign s_probe = sync_2[2:0];

    // Two-flop synchronisers for the enable switch and the probes {h, m, l}.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_1 <= '0;
            sync_2 <= '0;
        end else begin
            sync_1 <= {en, h_in, m_in, l_in};
            sync_2 <= sync_1;
        end
    end

    // Accept a probe change only after it has held for DEB_CYCLES samples.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            deb     <= '0;
            deb_cnt <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (s_probe[i] == deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == CW'(DEB_CYCLES - 1)) begin
                    deb[i]     <= s_probe[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + CW'(1);
                end
            end
        end
    end

    // A real tank can only read as a thermometer code: 000, 001, 011 or 111.
    assign code_valid = deb inside {3'b000, 3'b001, 3'b011, 3'b111};

    // State, counters and all outputs are registered together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= NORMAL;
            fcnt  <= '0;
            ccnt  <= '0;
            h     <= 1'b0;
            m     <= 1'b0;
            l     <= 1'b0;
            bs    <= 1'b0;
            m7    <= 1'b0;
        end else begin
            state <= state_n;
            fcnt  <= fcnt_n;
            ccnt  <= ccnt_n;
            h     <= h_n;
            m     <= m_n;
            l     <= l_n;
            bs    <= bs_n;
            m7    <= m7_n;
        end
    end

    // Next-state logic: the level display tracks valid codes, and the pump uses hysteresis.
    always_comb begin
        state_n = state;
        fcnt_n  = fcnt;
        ccnt_n  = ccnt;
        h_n     = h;
        m_n     = m;
        l_n     = l;
        bs_n    = bs;
        m7_n    = 1'b0;

        case (state)
            NORMAL: begin
                if (code_valid) begin
                    {h_n, m_n, l_n} = deb;
                    if (deb == 3'b000 || deb == 3'b001) begin
                        bs_n = 1'b1;
                    end else if (deb == 3'b111) begin
                        bs_n = 1'b0;
                    end
                end else begin
                    state_n = SUSPECT;
                    fcnt_n  = CW'(1);
                end
            end
            SUSPECT: begin
                if (code_valid) begin
                    state_n = NORMAL;
                    fcnt_n  = '0;
                end else if (fcnt == CW'(FAULT_CYCLES - 1)) begin
                    state_n = FAULT;
                    fcnt_n  = '0;
                    ccnt_n  = '0;
                end else begin
                    fcnt_n = fcnt + CW'(1);
                end
            end
            FAULT: begin
                bs_n = 1'b0;
                m7_n = 1'b1;
                if (code_valid) begin
                    if (ccnt == CW'(CLEAR_CYCLES - 1)) begin
                        state_n = NORMAL;
                        ccnt_n  = '0;
                        m7_n    = 1'b0;
                    end else begin
                        ccnt_n = ccnt + CW'(1);
                    end
                end else begin
                    ccnt_n = '0;
                end
            end
            default: begin
                state_n = NORMAL;
                fcnt_n  = '0;
                ccnt_n  = '0;
            end
        endcase

        if (!s_en) begin
            bs_n = 1'b0;
        end
    end

endmodule

// File: tb/tb_sensor_level_conditioner.sv
// tb_sensor_level_conditioner
// Directed bench for the tank level conditioner. A run-length behavioural
// model is compared against the DUT on every cycle. Hand-timed literal
// checks pin the latencies and the fault behaviour.
module tb_sensor_level_conditioner;

    localparam int DEB = 4;
    localparam int FLT = 3;
    localparam int CLR = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic en    = 1'b0;
    logic l_in  = 1'b0;
    logic m_in  = 1'b0;
    logic h_in  = 1'b0;
    logic l, m, h, bs, m7;

    int checks = 0;
    int errors = 0;
    bit done   = 1'b0;

    // Model state: input delay line, debounced levels, run lengths and mode.
    bit [3:0] p1, p2;
    bit [2:0] md;
    int       run [3];
    int       mode;
    int       prev_mode;
    int       bad_run;
    int       good_run;
    bit [2:0] mcode;
    bit       e_h, e_m, e_l, e_bs, e_m7;

    sensor_level_conditioner #(
        .DEB_CYCLES  (DEB),
        .FAULT_CYCLES(FLT),
        .CLEAR_CYCLES(CLR),
        .CW          (6)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (en),
        .l_in (l_in),
        .m_in (m_in),
        .h_in (h_in),
        .l    (l),
        .m    (m),
        .h    (h),
        .bs   (bs),
        .m7   (m7)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    function automatic bit thermo(input bit [2:0] c);
        return ((4'(c) + 4'd1) & 4'(c)) == 4'd0;
    endfunction

    task automatic check_output(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s @%0t: got %b, want %b", name, $time, act, exp);
        end
    endtask

    task automatic apply_stimulus(input bit e, input bit hv, input bit mv, input bit lv);
        en   = e;
        h_in = hv;
        m_in = mv;
        l_in = lv;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // The model advances on each rising edge, using the levels that were present before the edge.
    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                p1 = '0; p2 = '0; md = '0;
                for (int i = 0; i < 3; i++) run[i] = 0;
                mode = 0; bad_run = 0; good_run = 0;
                {e_h, e_m, e_l, e_bs, e_m7} = '0;
            end else begin
                mcode     = md;
                prev_mode = mode;
                case (mode)
                    0: begin
                        if (thermo(mcode)) begin
                            {e_h, e_m, e_l} = mcode;
                            if (mcode <= 3'b001) e_bs = 1'b1;
                            else if (mcode == 3'b111) e_bs = 1'b0;
                        end else begin
                            mode = 1; bad_run = 1;
                        end
                    end
                    1: begin
                        if (thermo(mcode)) begin
                            mode = 0;
                        end else begin
                            bad_run++;
                            if (bad_run == FLT) begin
                                mode = 2; good_run = 0;
                            end
                        end
                    end
                    default: begin
                        e_bs = 1'b0;
                        if (thermo(mcode)) begin
                            good_run++;
                            if (good_run == CLR) mode = 0;
                        end else begin
                            good_run = 0;
                        end
                    end
                endcase
                e_m7 = (prev_mode == 2) && (mode == 2);
                if (!p2[3]) e_bs = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    if (p2[i] != md[i]) begin
                        run[i]++;
                        if (run[i] == DEB) begin
                            md[i]  = p2[i];
                            run[i] = 0;
                        end
                    end else begin
                        run[i] = 0;
                    end
                end
                p2 = p1;
                p1 = {en, h_in, m_in, l_in};
            end
        end
    end

    // On every falling edge, the DUT outputs are compared against the model.
    initial begin
        while (!done) begin
            @(negedge clk);
            check_output("model_h", h, e_h);
            check_output("model_m", m, e_m);
            check_output("model_l", l, e_l);
            check_output("model_bs", bs, e_bs);
            check_output("model_m7", m7, e_m7);
        end
    end

    // Directed scenarios with hand-timed expectations.
    initial begin
        // Reset with the enable on and an empty tank
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        tick(3);
        check_output("rst_h", h, 1'b0);
        check_output("rst_m", m, 1'b0);
        check_output("rst_l", l, 1'b0);
        check_output("rst_bs", bs, 1'b0);
        check_output("rst_m7", m7, 1'b0);
        rst_n = 1'b1;
        tick(2);
        check_output("rel_bs_early", bs, 1'b0);
        tick(1);
        check_output("rel_bs_on", bs, 1'b1);

        // Fill the tank: low, then mid, then high
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1);
        tick(6);
        check_output("fill_l_before", l, 1'b0);
        tick(1);
        check_output("fill_l_after", l, 1'b1);
        check_output("fill_bs_001", bs, 1'b1);
        tick(13);
        apply_stimulus(1'b1, 1'b0, 1'b1, 1'b1);
        tick(7);
        check_output("fill_m_after", m, 1'b1);
        check_output("fill_bs_011", bs, 1'b1);
        tick(13);
        apply_stimulus(1'b1, 1'b1, 1'b1, 1'b1);
        tick(6);
        check_output("fill_bs_before_h", bs, 1'b1);
        tick(1);
        check_output("fill_h_after", h, 1'b1);
        check_output("fill_bs_full", bs, 1'b0);
        tick(13);

        // Drain: 011 keeps the pump off, and 001 turns it back on
        apply_stimulus(1'b1, 1'b0, 1'b1, 1'b1);
        tick(7);
        check_output("drain_h", h, 1'b0);
        check_output("drain_bs_011", bs, 1'b0);
        tick(13);
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1);
        tick(6);
        check_output("drain_bs_before", bs, 1'b0);
        tick(1);
        check_output("drain_bs_001", bs, 1'b1);
        tick(13);
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
        tick(20);

        // A short glitch on the mid probe must be filtered out
        apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0);
        tick(3);
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) begin
            tick(1);
            check_output("glitch_m", m, 1'b0);
            check_output("glitch_bs", bs, 1'b1);
        end

        // An impossible reading of 100 leads to FAULT
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0);
        tick(9);
        check_output("fault_m7_before", m7, 1'b0);
        check_output("fault_bs_hold", bs, 1'b1);
        tick(1);
        check_output("fault_m7", m7, 1'b1);
        check_output("fault_bs", bs, 1'b0);
        check_output("fault_h_frozen", h, 1'b0);
        check_output("fault_m_frozen", m, 1'b0);
        check_output("fault_l_frozen", l, 1'b0);
        tick(5);
        apply_stimulus(1'b1, 1'b1, 1'b1, 1'b1);
        tick(10);
        check_output("clear_m7_before", m7, 1'b1);
        tick(1);
        check_output("clear_m7", m7, 1'b0);
        tick(1);
        check_output("clear_h", h, 1'b1);
        check_output("clear_l", l, 1'b1);
        check_output("clear_bs", bs, 1'b0);

        // In FAULT, short valid stretches must not clear the flag
        apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0);
        tick(12);
        check_output("alt_enter_m7", m7, 1'b1);
        for (int k = 0; k < 8; k++) begin
            apply_stimulus(1'b1, 1'b1, 1'b1, (k % 2) == 0);
            for (int j = 0; j < 4; j++) begin
                tick(1);
                check_output("alt_m7", m7, 1'b1);
            end
        end
        apply_stimulus(1'b1, 1'b1, 1'b1, 1'b1);
        tick(20);
        check_output("alt_cleared_m7", m7, 1'b0);

        // Turning the enable off stops the pump 3 cycles later
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
        tick(10);
        check_output("en_bs_on", bs, 1'b1);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
        tick(2);
        check_output("en_off_bs_before", bs, 1'b1);
        tick(1);
        check_output("en_off_bs", bs, 1'b0);
        tick(3);
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
        tick(5);
        check_output("en_back_bs", bs, 1'b1);

        // Reset while in SUSPECT clears everything and returns to NORMAL
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0);
        tick(7);
        check_output("suspect_m7", m7, 1'b0);
        check_output("suspect_bs_hold", bs, 1'b1);
        rst_n = 1'b0;
        tick(1);
        check_output("midrst_bs", bs, 1'b0);
        check_output("midrst_h", h, 1'b0);
        check_output("midrst_m7", m7, 1'b0);
        tick(2);
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick(2);
        check_output("postrst_bs_early", bs, 1'b0);
        tick(1);
        check_output("postrst_bs", bs, 1'b1);
        tick(10);
        check_output("postrst_m7", m7, 1'b0);

        done = 1'b1;
        tick(1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
